regfile_writeback_arbiter: RTL and testbench
============================================

// Module: regfile_writeback_arbiter
// PURPOSE
//  Write-side initiator for the 32x64 four-read/two-write register file. Collects results from
//  NUM_SRC producers (ALU0, ALU1, MEM) over valid/ready, buffers one result per source, and drives
//  the register file's two write ports, at most two writes per cycle to distinct registers.
//  Exports a busy mask of registers with writes in flight, for issue-side hazard checks.
// PARAMETERS
//  NUM_SRC       3    number of result sources; index 0 = highest priority
//  DATA_W        64   register data width
//  ADDR_W        5    register index width (2**ADDR_W registers; register 0 is hardwired zero)
//  STARVE_LIMIT  4    consecutive denied cycles before a source is promoted
// PORTS
//  clk           in   1               clock, all state updates on rising edge
//  reset         in   1               synchronous, active-low reset
//  src_valid     in   NUM_SRC         source i presents a result
//  src_ready     out  NUM_SRC         source i holding slot can accept this cycle
//  src_addr      in   NUM_SRC*ADDR_W  destination register, source i in bits [i*ADDR_W +: ADDR_W]
//  src_data      in   NUM_SRC*DATA_W  result data, source i in bits [i*DATA_W +: DATA_W]
//  write_port_1  out  ADDR_W          register file write address 1 (0 = no write)
//  write_data_1  out  DATA_W          register file write data 1
//  write_port_2  out  ADDR_W          register file write address 2 (0 = no write)
//  write_data_2  out  DATA_W          register file write data 2
//  busy_mask     out  2**ADDR_W       bit r set = a write to register r is held or on a write port
// BEHAVIOUR
//  Reset (reset==0 at edge): all slots empty, write_port_*/write_data_* = 0, starvation counters = 0.
//   While reset==0, src_ready = 0; busy_mask = 0 after the reset edge.
//  Slots: one entry {addr,data} per source. src_ready[i] = slot empty | slot granted this cycle.
//   Transfer = src_valid & src_ready at edge; slot loads. Transfer with addr==0 is accepted, dropped.
//  Grant (combinational, each cycle, from occupied slots):
//   - Priority order: starved sources first (ascending index), then non-starved (ascending index).
//   - First candidate -> grant A. Next candidate whose addr != A's addr -> grant B. Same-addr
//     candidates are skipped and stay held.
//   - Granted slots empty at the edge; may reload the same edge (src_ready already high).
//  Write ports (registered): at the edge, write_port_1/data_1 <= grant A (else 0);
//   write_port_2/data_2 <= grant B (else 0). Never equal nonzero addresses in one cycle.
//   Latency: transfer at edge k -> on write port after edge k+1 -> register file written at edge k+2.
//   Unused write port drives address 0; data is don't-care but stays 0.
//  Starvation: per-source counter, width $clog2(STARVE_LIMIT+1). Increments (saturating at
//   STARVE_LIMIT) when slot occupied and not granted; clears on grant or empty slot.
//   Starved = counter == STARVE_LIMIT.
//  busy_mask: OR of one-hot(addr) for occupied slots, write_port_1 and write_port_2; bit 0 forced 0.
//   Combinational from state only, no dependence on src_* inputs.
//  Boundaries: all sources valid with equal addr -> one write per cycle, highest priority first.
//   Reset mid-stream discards held and in-flight writes; write ports read 0 on the cycle after.
//   No combinational path from src_valid to src_ready.
// STRUCTURE
//  Shared package regfile_pkg: ADDR_W, DATA_W, NUM_REGS, ZERO_REG, typedef wb_req_t {addr,data}.
//  Sub-module regfile_wb_pick2: combinational pick-two with priority vector and address-conflict
//   skip; returns grant_a/grant_b one-hot plus valid bits. Slots, counters, outputs stay in top.
// TESTING
//  1. Reset low 2 cycles, src_valid=3'b111 -> src_ready=0, ports 0, busy_mask=0; ready=3'b111 after release.
//  2. Src0 addr 5 data 0xAA, src1 addr 7 data 0xBB, same edge k -> after k+1: port1=5/0xAA,
//     port2=7/0xBB; busy_mask bits 5,7 set during slot cycle and port cycle, then clear.
//  3. Src0, src1, src2 all addr 9 (data 1, 2, 3), held valid -> port1=9 with data 1, 2, 3 on
//     successive cycles, port2=0 throughout.
//  4. Src0 and src1 stream every cycle to distinct regs, src2 addr 12 held -> src2 granted within
//     STARVE_LIMIT+1 cycles of its slot loading, on port1.
//  5. Any src addr 0 -> accepted (ready high), no port activity, busy_mask unchanged.
//  6. Reset low while three slots full and ports active -> next cycle ports 0, busy_mask 0, no write.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file write side: register geometry,
// the {addr,data} write request and a helper that turns a register index into a busy bit.
package regfile_pkg;

    localparam int ADDR_W           = 5;
    localparam int DATA_W           = 64;
    localparam int NUM_REGS         = 2 ** ADDR_W;
    localparam int DEF_NUM_SRC      = 3;
    localparam int DEF_STARVE_LIMIT = 4;

    localparam logic [ADDR_W-1:0] ZERO_REG = '0;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_req_t;

    // Register 0 is hardwired zero, so it never shows up as busy.
    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [ADDR_W-1:0] addr);
        logic [NUM_REGS-1:0] mask;
        mask           = '0;
        mask[addr]     = 1'b1;
        mask[ZERO_REG] = 1'b0;
        return mask;
    endfunction

endpackage

// File: rtl/regfile_wb_pick2.sv
// Combinational pick-two: starved requesters first, then the rest, each in ascending index;
// the second grant must target a different register than the first.
module regfile_wb_pick2
    import regfile_pkg::*;
#(
    parameter int NUM_SRC = DEF_NUM_SRC
) (
    input  logic [NUM_SRC-1:0]        req,
    input  logic [NUM_SRC-1:0]        starved,
    input  logic [NUM_SRC*ADDR_W-1:0] req_addr,
    output logic [NUM_SRC-1:0]        grant_a,
    output logic                      grant_a_valid,
    output logic [NUM_SRC-1:0]        grant_b,
    output logic                      grant_b_valid
);

    logic [ADDR_W-1:0] addr_a;

    // Pass 0 walks starved requesters, pass 1 the non-starved ones.
    always_comb begin
        grant_a       = '0;
        grant_b       = '0;
        grant_a_valid = 1'b0;
        grant_b_valid = 1'b0;
        addr_a        = '0;
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (req[i] && (starved[i] == (pass == 0))) begin
                    if (!grant_a_valid) begin
                        grant_a[i]    = 1'b1;
                        grant_a_valid = 1'b1;
                        addr_a        = req_addr[i*ADDR_W +: ADDR_W];
                    end else if (!grant_b_valid &&
                                 (req_addr[i*ADDR_W +: ADDR_W] != addr_a)) begin
                        grant_b[i]    = 1'b1;
                        grant_b_valid = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/regfile_writeback_arbiter.sv
// Write-side initiator for the register file: one holding slot per result source, two
// registered write ports fed by a conflict-free pick-two, plus a busy mask for issue hazards.
module regfile_writeback_arbiter
    import regfile_pkg::*;
#(
    parameter int NUM_SRC      = DEF_NUM_SRC,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_SRC-1:0]        src_valid,
    output logic [NUM_SRC-1:0]        src_ready,
    input  logic [NUM_SRC*ADDR_W-1:0] src_addr,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    output logic [ADDR_W-1:0]         write_port_1,
    output logic [DATA_W-1:0]         write_data_1,
    output logic [ADDR_W-1:0]         write_port_2,
    output logic [DATA_W-1:0]         write_data_2,
    output logic [NUM_REGS-1:0]       busy_mask
);

    localparam int              CNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    wb_req_t            slot_q       [NUM_SRC];
    wb_req_t            slot_d       [NUM_SRC];
    logic [NUM_SRC-1:0] slot_valid_q;
    logic [NUM_SRC-1:0] slot_valid_d;
    logic [CNT_W-1:0]   starve_cnt_q [NUM_SRC];
    logic [CNT_W-1:0]   starve_cnt_d [NUM_SRC];
    wb_req_t            port1_q;
    wb_req_t            port1_d;
    wb_req_t            port2_q;
    wb_req_t            port2_d;

    logic [NUM_SRC-1:0]        starved;
    logic [NUM_SRC*ADDR_W-1:0] slot_addr_flat;
    logic [NUM_SRC-1:0]        grant_a;
    logic [NUM_SRC-1:0]        grant_b;
    logic                      grant_a_valid;
    logic                      grant_b_valid;
    logic [NUM_SRC-1:0]        granted;

    always_comb begin
        starved        = '0;
        slot_addr_flat = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            starved[i]                          = (starve_cnt_q[i] == CNT_MAX);
            slot_addr_flat[i*ADDR_W +: ADDR_W]  = slot_q[i].addr;
        end
    end

    regfile_wb_pick2 #(
        .NUM_SRC (NUM_SRC)
    ) u_pick2 (
        .req           (slot_valid_q),
        .starved       (starved),
        .req_addr      (slot_addr_flat),
        .grant_a       (grant_a),
        .grant_a_valid (grant_a_valid),
        .grant_b       (grant_b),
        .grant_b_valid (grant_b_valid)
    );

    // Ready depends only on slot state and grants, never on src_valid.
    always_comb begin
        granted   = (grant_a_valid ? grant_a : '0) | (grant_b_valid ? grant_b : '0);
        src_ready = reset ? (~slot_valid_q | granted) : '0;
    end

    always_comb begin
        port1_d = '0;
        port2_d = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            slot_d[i]       = slot_q[i];
            slot_valid_d[i] = slot_valid_q[i];
            starve_cnt_d[i] = '0;
            if (granted[i]) begin
                slot_valid_d[i] = 1'b0;
            end
            // A write to the zero register is accepted but never occupies the slot.
            if (src_valid[i] && src_ready[i]) begin
                slot_d[i].addr  = src_addr[i*ADDR_W +: ADDR_W];
                slot_d[i].data  = src_data[i*DATA_W +: DATA_W];
                slot_valid_d[i] = (src_addr[i*ADDR_W +: ADDR_W] != ZERO_REG);
            end
            if (slot_valid_q[i] && !granted[i]) begin
                starve_cnt_d[i] = (starve_cnt_q[i] == CNT_MAX) ? CNT_MAX
                                                               : starve_cnt_q[i] + 1'b1;
            end
            if (grant_a_valid && grant_a[i]) begin
                port1_d = slot_q[i];
            end
            if (grant_b_valid && grant_b[i]) begin
                port2_d = slot_q[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            slot_valid_q <= '0;
            port1_q      <= '0;
            port2_q      <= '0;
            for (int i = 0; i < NUM_SRC; i++) begin
                slot_q[i]       <= '0;
                starve_cnt_q[i] <= '0;
            end
        end else begin
            slot_valid_q <= slot_valid_d;
            port1_q      <= port1_d;
            port2_q      <= port2_d;
            for (int i = 0; i < NUM_SRC; i++) begin
                slot_q[i]       <= slot_d[i];
                starve_cnt_q[i] <= starve_cnt_d[i];
            end
        end
    end

    always_comb begin
        write_port_1 = port1_q.addr;
        write_data_1 = port1_q.data;
        write_port_2 = port2_q.addr;
        write_data_2 = port2_q.data;
    end

    always_comb begin
        busy_mask = reg_onehot(port1_q.addr) | reg_onehot(port2_q.addr);
        for (int i = 0; i < NUM_SRC; i++) begin
            if (slot_valid_q[i]) begin
                busy_mask = busy_mask | reg_onehot(slot_q[i].addr);
            end
        end
    end

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// Directed bench for regfile_writeback_arbiter: expected write-port/busy states are queued
// as each step is driven and popped one per clock edge.
module tb_regfile_writeback_arbiter;
    import regfile_pkg::*;

    localparam int NS = DEF_NUM_SRC;
    localparam int SL = DEF_STARVE_LIMIT;

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic [NS-1:0]        src_valid = '0;
    logic [NS-1:0]        src_ready;
    logic [NS*ADDR_W-1:0] src_addr = '0;
    logic [NS*DATA_W-1:0] src_data = '0;
    logic [ADDR_W-1:0]    write_port_1;
    logic [DATA_W-1:0]    write_data_1;
    logic [ADDR_W-1:0]    write_port_2;
    logic [DATA_W-1:0]    write_data_2;
    logic [NUM_REGS-1:0]  busy_mask;

    typedef struct {
        logic [ADDR_W-1:0]   p1;
        logic [DATA_W-1:0]   d1;
        logic [ADDR_W-1:0]   p2;
        logic [DATA_W-1:0]   d2;
        logic [NUM_REGS-1:0] busy;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    regfile_writeback_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .src_valid    (src_valid),
        .src_ready    (src_ready),
        .src_addr     (src_addr),
        .src_data     (src_data),
        .write_port_1 (write_port_1),
        .write_data_1 (write_data_1),
        .write_port_2 (write_port_2),
        .write_data_2 (write_data_2),
        .busy_mask    (busy_mask)
    );

    always #5 clk = ~clk;

    function automatic logic [NUM_REGS-1:0] bm(input int a, input int b, input int c,
                                               input int d, input int e);
        logic [NUM_REGS-1:0] m;
        m = '0;
        if (a != 0) m[a] = 1'b1;
        if (b != 0) m[b] = 1'b1;
        if (c != 0) m[c] = 1'b1;
        if (d != 0) m[d] = 1'b1;
        if (e != 0) m[e] = 1'b1;
        return m;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input int p1, input logic [DATA_W-1:0] d1, input int p2,
                            input logic [DATA_W-1:0] d2, input logic [NUM_REGS-1:0] busy);
        exp_t e;
        e.p1   = ADDR_W'(p1);
        e.d1   = d1;
        e.p2   = ADDR_W'(p2);
        e.d2   = d2;
        e.busy = busy;
        sb.push_back(e);
    endtask

    task automatic set_src(input int i, input int addr, input logic [DATA_W-1:0] data);
        src_addr[i*ADDR_W +: ADDR_W] = ADDR_W'(addr);
        src_data[i*DATA_W +: DATA_W] = data;
    endtask

    task automatic check_output();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard_underflow: observed empty queue expected an entry");
        end else begin
            e = sb.pop_front();
            check("write_port_1", 64'(write_port_1), 64'(e.p1));
            check("write_data_1", write_data_1, e.d1);
            check("write_port_2", 64'(write_port_2), 64'(e.p2));
            check("write_data_2", write_data_2, e.d2);
            check("busy_mask", 64'(busy_mask), 64'(e.busy));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        check_output();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL timeout: observed no finish expected finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        // Reset held two cycles with every source asserting valid.
        src_valid = 3'b111;
        push_exp(0, 0, 0, 0, '0);
        push_exp(0, 0, 0, 0, '0);
        tick();
        tick();
        check("ready_in_reset", 64'(src_ready), 64'(3'b000));
        src_valid = '0;
        reset     = 1'b1;
        #1;
        check("ready_after_release", 64'(src_ready), 64'(3'b111));

        // Two sources, distinct registers, same edge.
        set_src(0, 5, 64'hAA);
        set_src(1, 7, 64'hBB);
        src_valid = 3'b011;
        push_exp(0, 0, 0, 0, bm(5, 7, 0, 0, 0));
        tick();
        src_valid = '0;
        push_exp(5, 64'hAA, 7, 64'hBB, bm(5, 7, 0, 0, 0));
        push_exp(0, 0, 0, 0, '0);
        tick();
        tick();

        // All three sources to register 9: one write per cycle in priority order.
        set_src(0, 9, 64'h1);
        set_src(1, 9, 64'h2);
        set_src(2, 9, 64'h3);
        src_valid = 3'b111;
        push_exp(0, 0, 0, 0, bm(9, 0, 0, 0, 0));
        tick();
        src_valid = '0;
        push_exp(9, 64'h1, 0, 0, bm(9, 0, 0, 0, 0));
        push_exp(9, 64'h2, 0, 0, bm(9, 0, 0, 0, 0));
        push_exp(9, 64'h3, 0, 0, bm(9, 0, 0, 0, 0));
        push_exp(0, 0, 0, 0, '0);
        repeat (4) tick();

        // Sources 0/1 stream continuously; source 2 must be promoted after starving.
        set_src(0, 1, 64'h10);
        set_src(1, 2, 64'h20);
        set_src(2, 12, 64'hC0);
        src_valid = 3'b111;
        push_exp(0, 0, 0, 0, bm(1, 2, 12, 0, 0));
        tick();
        src_valid = 3'b011;
        for (int j = 0; j < SL; j++) begin
            push_exp(1, 64'h10, 2, 64'h20, bm(1, 2, 12, 0, 0));
            tick();
        end
        check("ready_starved_cycle", 64'(src_ready), 64'(3'b101));
        src_valid = '0;
        push_exp(12, 64'hC0, 1, 64'h10, bm(1, 2, 12, 0, 0));
        push_exp(2, 64'h20, 0, 0, bm(2, 0, 0, 0, 0));
        push_exp(0, 0, 0, 0, '0);
        repeat (3) tick();

        // Write to register 0 is accepted and dropped.
        set_src(0, 0, 64'hDEAD);
        src_valid = 3'b001;
        check("ready_zero_reg", 64'(src_ready), 64'(3'b111));
        push_exp(0, 0, 0, 0, '0);
        tick();
        src_valid = '0;
        push_exp(0, 0, 0, 0, '0);
        tick();

        // Reset with all slots full and both ports active.
        set_src(0, 3, 64'h33);
        set_src(1, 4, 64'h44);
        set_src(2, 6, 64'h66);
        src_valid = 3'b111;
        push_exp(0, 0, 0, 0, bm(3, 4, 6, 0, 0));
        tick();
        set_src(0, 10, 64'hAA0);
        set_src(1, 11, 64'hBB0);
        src_valid = 3'b011;
        push_exp(3, 64'h33, 4, 64'h44, bm(3, 4, 6, 10, 11));
        tick();
        src_valid = '0;
        reset     = 1'b0;
        push_exp(0, 0, 0, 0, '0);
        tick();
        check("ready_mid_reset", 64'(src_ready), 64'(3'b000));
        reset = 1'b1;
        #1;
        check("ready_post_reset", 64'(src_ready), 64'(3'b111));
        push_exp(0, 0, 0, 0, '0);
        tick();

        check("scoreboard_drain", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
